// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding and register-file constants.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard compare between the EX load destination and the ID source registers.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_dst,
    output logic             hazard
);

    logic [REG_W-1:0] src_reg_num [2];
    logic [1:0]       src_used;
    logic [1:0]       src_match;

    assign src_reg_num[0] = id_rs;
    assign src_reg_num[1] = id_rt;
    assign src_used       = {id_use_rt, id_use_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = src_used[gi] && (src_reg_num[gi] == ex_dst);
        end
    endgenerate

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign hazard = ex_load && (ex_dst != REG_ZERO) && (|src_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: memory-wait FSM, load-use stall, branch flush and event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             hold_pc,
    output logic             pause_fi_id,
    output logic             pause_id_ex,
    output logic             pause_ex_mem,
    output logic             pause_mem_wb,
    output logic             flush_fi_id,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    pipe_state_e       state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg, mem_err_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;

    logic load_use;
    logic freeze_all;
    logic lu_stall;
    logic br_flush;
    logic any_pause;

    load_use_detect u_load_use_detect (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .ex_load   (ex_load),
        .ex_dst    (ex_dst),
        .hazard    (load_use)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            mem_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            mem_err_reg   <= mem_err_next;
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Next state plus the three mutually exclusive control actions, in priority order.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;
        freeze_all    = 1'b0;
        lu_stall      = 1'b0;
        br_flush      = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    freeze_all    = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = '0;
                end else if (load_use) begin
                    lu_stall = 1'b1;
                end else if (branch_taken) begin
                    br_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                freeze_all = 1'b1;
                if (mem_ack) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    if (wait_cnt_reg >= WAIT_LAST) begin
                        state_next   = ST_ERR;
                        mem_err_next = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                freeze_all = 1'b1;
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase

        // Outputs are forced low while reset is held, independent of the inputs.
        if (!rst) begin
            freeze_all = 1'b0;
            lu_stall   = 1'b0;
            br_flush   = 1'b0;
        end
    end

    assign hold_pc      = freeze_all || lu_stall;
    assign pause_fi_id  = freeze_all || lu_stall;
    // A load-use stall leaves ID/EX running so a single bubble enters EX.
    assign pause_id_ex  = freeze_all;
    assign pause_ex_mem = freeze_all;
    assign pause_mem_wb = freeze_all;
    assign flush_fi_id  = br_flush;

    assign any_pause = pause_fi_id || pause_id_ex || pause_ex_mem || pause_mem_wb;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (any_pause && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
        if (flush_fi_id && (flush_cnt_reg != '1)) begin
            flush_cnt_next = flush_cnt_reg + CNT_W'(1);
        end
    end

    assign mem_err   = mem_err_reg;
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; counters narrowed to 4 bits so saturation is reachable.
module tb_pipe_ctrl;

    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 15;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_dst;
    logic             id_use_rs, id_use_rt, ex_load;
    logic             branch_taken, mem_req, mem_ack;
    logic             hold_pc, pause_fi_id, pause_id_ex, pause_ex_mem, pause_mem_wb;
    logic             flush_fi_id, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // {hold_pc, pause_fi_id, pause_id_ex, pause_ex_mem, pause_mem_wb, flush_fi_id}
    localparam logic [5:0] O_IDLE   = 6'b000000;
    localparam logic [5:0] O_LU     = 6'b110000;
    localparam logic [5:0] O_FREEZE = 6'b111110;
    localparam logic [5:0] O_FLUSH  = 6'b000001;

    logic [5:0] outs;
    assign outs = {hold_pc, pause_fi_id, pause_id_ex, pause_ex_mem, pause_mem_wb, flush_fi_id};

    pipe_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_load      (ex_load),
        .ex_dst       (ex_dst),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .hold_pc      (hold_pc),
        .pause_fi_id  (pause_fi_id),
        .pause_id_ex  (pause_id_ex),
        .pause_ex_mem (pause_ex_mem),
        .pause_mem_wb (pause_mem_wb),
        .flush_fi_id  (flush_fi_id),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic set_in(input logic ld, input logic [4:0] dst,
                          input logic urs, input logic [4:0] rs,
                          input logic urt, input logic [4:0] rt,
                          input logic br, input logic req, input logic ack);
        ex_load      = ld;
        ex_dst       = dst;
        id_use_rs    = urs;
        id_rs        = rs;
        id_use_rt    = urt;
        id_rt        = rt;
        branch_taken = br;
        mem_req      = req;
        mem_ack      = ack;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drive on the falling edge, sample 1 ns later, well away from the rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        // Hazard, branch and memory stall all requested while reset is held.
        set_in(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        #1;
        check("reset_outs", 32'(outs), 32'(O_IDLE));
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        check("reset_flush_cnt", 32'(flush_cnt), 0);
        check("reset_mem_err", 32'(mem_err), 0);
        step(); step();
        #1 check("reset_held_outs", 32'(outs), 32'(O_IDLE));
        check("reset_held_stall_cnt", 32'(stall_cnt), 0);
        idle();
        rst = 1'b1;
        step(); #1 check("idle_outs", 32'(outs), 32'(O_IDLE));

        // Load-use on rs
        step();
        set_in(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check("lu_rs_outs", 32'(outs), 32'(O_LU));
        step(); idle();
        #1 check("lu_rs_after_outs", 32'(outs), 32'(O_IDLE));
        check("lu_rs_stall_cnt", 32'(stall_cnt), 1);

        // Register zero never hazards
        step();
        set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check("r0_outs", 32'(outs), 32'(O_IDLE));
        step(); idle();
        #1 check("r0_stall_cnt", 32'(stall_cnt), 1);

        // Match on rt but rt not used: no hazard
        set_in(1'b1, 5'd7, 1'b0, 5'd3, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        #1 check("rt_unused_outs", 32'(outs), 32'(O_IDLE));
        // Non-load with matching rs: no hazard
        step();
        set_in(1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check("no_load_outs", 32'(outs), 32'(O_IDLE));
        // Load-use on rt
        step();
        set_in(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        #1 check("lu_rt_outs", 32'(outs), 32'(O_LU));
        step(); idle();
        #1 check("lu_rt_stall_cnt", 32'(stall_cnt), 2);

        // Branch flush
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("flush_outs", 32'(outs), 32'(O_FLUSH));
        step(); idle();
        #1 check("flush_one_cycle_outs", 32'(outs), 32'(O_IDLE));
        check("flush_cnt_1", 32'(flush_cnt), 1);

        // Hazard beats branch
        set_in(1'b1, 5'd12, 1'b1, 5'd12, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("prio_lu_br_outs", 32'(outs), 32'(O_LU));
        step(); idle();
        #1 check("prio_flush_cnt", 32'(flush_cnt), 1);
        check("prio_stall_cnt", 32'(stall_cnt), 3);

        // Memory wait, ack arrives 3 cycles after the request; hazard and branch suppressed
        set_in(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        #1 check("mw_c0_outs", 32'(outs), 32'(O_FREEZE));
        for (int c = 1; c <= 3; c++) begin
            step();
            set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, (c == 3));
            #1 check($sformatf("mw_c%0d_outs", c), 32'(outs), 32'(O_FREEZE));
        end
        step(); idle();
        #1 check("mw_back_run_outs", 32'(outs), 32'(O_IDLE));
        check("mw_stall_cnt", 32'(stall_cnt), 7);
        check("mw_flush_cnt", 32'(flush_cnt), 1);

        // Request with same-cycle ack does not stall
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #1 check("req_ack_outs", 32'(outs), 32'(O_IDLE));
        step(); idle();
        #1 check("req_ack_stall_cnt", 32'(stall_cnt), 7);

        // Flush counter to all-ones (1 -> 15), then two more flushes
        for (int f = 0; f < 14; f++) begin
            set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
            step();
        end
        idle();
        #1 check("flush_cnt_full", 32'(flush_cnt), 15);
        for (int f = 0; f < 2; f++) begin
            set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
            #1 check($sformatf("sat_flush%0d_outs", f), 32'(outs), 32'(O_FLUSH));
            step();
        end
        idle();
        #1 check("flush_cnt_sat", 32'(flush_cnt), 15);

        // Timeout: request held with no ack
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1 check("to_c0_outs", 32'(outs), 32'(O_FREEZE));
        for (int c = 1; c <= MEM_TIMEOUT; c++) begin
            step();
            #1 check($sformatf("to_wait%0d_err", c), 32'(mem_err), 0);
        end
        step();
        #1 check("to_mem_err", 32'(mem_err), 1);
        check("to_err_outs", 32'(outs), 32'(O_FREEZE));
        // ERR ignores ack and keeps everything frozen
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        step(); step();
        #1 check("err_held_outs", 32'(outs), 32'(O_FREEZE));
        check("err_held_mem_err", 32'(mem_err), 1);
        check("stall_cnt_sat", 32'(stall_cnt), 15);

        // Reset mid-cycle from ERR
        #1 rst = 1'b0;
        #1 check("err_rst_outs", 32'(outs), 32'(O_IDLE));
        check("err_rst_mem_err", 32'(mem_err), 0);
        check("err_rst_stall_cnt", 32'(stall_cnt), 0);
        check("err_rst_flush_cnt", 32'(flush_cnt), 0);
        step(); idle();
        rst = 1'b1;
        step();
        // Back in RUN: a branch flushes rather than staying frozen
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("post_rst_run_outs", 32'(outs), 32'(O_FLUSH));
        step(); idle();
        #1 check("post_rst_flush_cnt", 32'(flush_cnt), 1);
        check("post_rst_mem_err", 32'(mem_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
